// File: rtl/pcis_rd_resp_axi_formatter_pkg.sv
// Shared types for the PCIS read-response formatter.
//   - Bus widths for the AXI read-data channel and the burst descriptor.
//   - rd_desc_t: the burst descriptor {valid, arid, beat count}. It has the
//     same layout as the read-ID queue entry that the packetizer produces.
//   - AXI_RRESP_OKAY: the only response code this block emits.
//   - fmt_state_e: the burst sequencer states.
package pcis_rd_resp_axi_formatter_pkg;
  localparam int ID_WIDTH   = 6;
  localparam int DATA_WIDTH = 512;
  localparam int LEN_WIDTH  = 9;   // holds 1..256, so the width is 9 bits

  localparam logic [1:0] AXI_RRESP_OKAY = 2'b00;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } fmt_state_e;

  typedef struct packed {
    logic                 valid;
    logic [ID_WIDTH-1:0]  arid;
    logic [LEN_WIDTH-1:0] beats;   // arlen + 1
  } rd_desc_t;
endpackage

// File: rtl/pcis_rd_resp_axi_formatter_if.sv
// Groups the descriptor pop, the response-packet pop and the AXI R channel.
//   slave  : the formatter side. It pops descriptors and packets and drives R.
//   master : the environment side. It is the queues plus the host R sink.
interface pcis_rd_resp_axi_formatter_if
  import pcis_rd_resp_axi_formatter_pkg::*;
;
  logic                  desc_valid;
  logic [ID_WIDTH-1:0]   desc_id;
  logic [LEN_WIDTH-1:0]  desc_beats;
  logic                  desc_ready;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_data;
  logic                  resp_accept;
  logic [ID_WIDTH-1:0]   cl_sh_dma_pcis_rid;
  logic [DATA_WIDTH-1:0] cl_sh_dma_pcis_rdata;
  logic [1:0]            cl_sh_dma_pcis_rresp;
  logic                  cl_sh_dma_pcis_rlast;
  logic                  cl_sh_dma_pcis_rvalid;
  logic                  sh_cl_dma_pcis_rready;
  logic                  zero_len_err;

  modport slave (
    input  desc_valid, desc_id, desc_beats, resp_valid, resp_data,
           sh_cl_dma_pcis_rready,
    output desc_ready, resp_accept, cl_sh_dma_pcis_rid, cl_sh_dma_pcis_rdata,
           cl_sh_dma_pcis_rresp, cl_sh_dma_pcis_rlast, cl_sh_dma_pcis_rvalid,
           zero_len_err
  );

  modport master (
    output desc_valid, desc_id, desc_beats, resp_valid, resp_data,
           sh_cl_dma_pcis_rready,
    input  desc_ready, resp_accept, cl_sh_dma_pcis_rid, cl_sh_dma_pcis_rdata,
           cl_sh_dma_pcis_rresp, cl_sh_dma_pcis_rlast, cl_sh_dma_pcis_rvalid,
           zero_len_err
  );
endinterface

// File: rtl/pcis_rd_resp_axi_formatter.sv
// PCIS read-response AXI formatter.
// For each burst, this block pops one descriptor {arid, beats}. It then turns
// that many 512-bit response packets into AXI R beats, with rid, rresp=OKAY
// and rlast. A single output register holds each beat until the host
// accepts it. The register can load and drain in the same cycle, so a burst
// streams at one beat per clock.
// Ports:
//   clk   : sole clock
//   rst_n : asynchronous active-low reset
//   bus   : descriptor pop, response-packet pop, AXI R channel and
//           zero_len_err (slave modport)
module pcis_rd_resp_axi_formatter
  import pcis_rd_resp_axi_formatter_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst_n,
  pcis_rd_resp_axi_formatter_if.slave    bus
);
  fmt_state_e            state_q, state_d;
  logic [LEN_WIDTH-1:0]  beats_left_q, beats_left_d;
  logic [ID_WIDTH-1:0]   cur_id_q, cur_id_d;
  logic                  rvalid_q, rvalid_d;
  logic                  rlast_q, rlast_d;
  logic [ID_WIDTH-1:0]   rid_q, rid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  zerr_q, zerr_d;

  rd_desc_t desc_in;
  logic     desc_rdy, desc_pop, out_free, accept, last_beat;

  assign desc_in   = '{valid: bus.desc_valid, arid: bus.desc_id, beats: bus.desc_beats};
  assign desc_pop  = desc_in.valid && desc_rdy;
  assign out_free  = !rvalid_q || bus.sh_cl_dma_pcis_rready;
  assign last_beat = (beats_left_q == LEN_WIDTH'(1));

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state. A zero-beat descriptor is popped but keeps us in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (desc_pop && desc_in.beats != '0) state_d = ST_STREAM;
      ST_STREAM: if (accept && last_beat)             state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs. The pop strobes are gated by rst_n so that they stay low
  // for the whole time reset is held. Packets are never accepted in IDLE,
  // so a packet cannot cross a burst boundary.
  always_comb begin
    desc_rdy = rst_n && (state_q == ST_IDLE);
    accept   = rst_n && (state_q == ST_STREAM) && bus.resp_valid && out_free;
  end

  // Burst tracking and the output holding register
  always_comb begin
    beats_left_d = beats_left_q;
    cur_id_d     = cur_id_q;
    rvalid_d     = rvalid_q;
    rlast_d      = rlast_q;
    rid_d        = rid_q;
    rdata_d      = rdata_q;
    zerr_d       = zerr_q;
    if (desc_pop) begin
      if (desc_in.beats != '0) begin
        cur_id_d     = desc_in.arid;
        beats_left_d = desc_in.beats;
      end else begin
        zerr_d = 1'b1;
      end
    end
    if (accept) begin
      rvalid_d     = 1'b1;
      rdata_d      = bus.resp_data;
      rid_d        = cur_id_q;
      rlast_d      = last_beat;
      beats_left_d = beats_left_q - LEN_WIDTH'(1);
    end else if (bus.sh_cl_dma_pcis_rready) begin
      rvalid_d = 1'b0;   // drained with nothing to refill; payload left as-is
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beats_left_q <= '0;
      cur_id_q     <= '0;
      rvalid_q     <= 1'b0;
      rlast_q      <= 1'b0;
      rid_q        <= '0;
      rdata_q      <= '0;
      zerr_q       <= 1'b0;
    end else begin
      beats_left_q <= beats_left_d;
      cur_id_q     <= cur_id_d;
      rvalid_q     <= rvalid_d;
      rlast_q      <= rlast_d;
      rid_q        <= rid_d;
      rdata_q      <= rdata_d;
      zerr_q       <= zerr_d;
    end
  end

  assign bus.desc_ready            = desc_rdy;
  assign bus.resp_accept           = accept;
  assign bus.cl_sh_dma_pcis_rvalid = rvalid_q;
  assign bus.cl_sh_dma_pcis_rlast  = rlast_q;
  assign bus.cl_sh_dma_pcis_rid    = rid_q;
  assign bus.cl_sh_dma_pcis_rdata  = rdata_q;
  assign bus.cl_sh_dma_pcis_rresp  = AXI_RRESP_OKAY;
  assign bus.zero_len_err          = zerr_q;
endmodule

// File: tb/tb_pcis_rd_resp_axi_formatter.sv
// Bench for pcis_rd_resp_axi_formatter.
// The descriptor and packet sources are queues, popped on handshake.
// send() derives the expected R beats directly from each burst: the packets
// are consumed in order and the last beat of each burst carries rlast.
// A separate monitor pops the expected beats and compares them on every
// R handshake.
module tb_pcis_rd_resp_axi_formatter;
  import pcis_rd_resp_axi_formatter_pkg::*;

  typedef struct { logic [ID_WIDTH-1:0] id; logic [LEN_WIDTH-1:0] beats; } d_t;
  typedef struct { logic [ID_WIDTH-1:0] id; logic [DATA_WIDTH-1:0] data; logic last; } e_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pcis_rd_resp_axi_formatter_if bus();
  pcis_rd_resp_axi_formatter dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  d_t                    desc_q[$];
  logic [DATA_WIDTH-1:0] resp_q[$];
  e_t                    exp_q[$];
  int                    hs_cyc[$];
  int n_cmp = 0, n_fail = 0, cyc = 0;
  int rr_mode = 0;      // 0: rready high, 1: rready random 50%, 2: rready low
  bit rnd_gaps = 0;

  task automatic chk(input string nm, input logic [DATA_WIDTH-1:0] act, input logic [DATA_WIDTH-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic send(input logic [ID_WIDTH-1:0] id, input int beats, input bit pat_a5);
    logic [DATA_WIDTH-1:0] d;
    e_t e;
    desc_q.push_back('{id: id, beats: LEN_WIDTH'(beats)});
    for (int i = 0; i < beats; i++) begin
      if (pat_a5) d = {(DATA_WIDTH/8){8'hA5}};
      else for (int w = 0; w < DATA_WIDTH/32; w++) d[w*32 +: 32] = $urandom;
      resp_q.push_back(d);
      e.id = id; e.data = d; e.last = (i == beats - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic drain(input int max_cyc);
    int n = 0;
    while (exp_q.size() != 0 || desc_q.size() != 0 || resp_q.size() != 0) begin
      @(negedge clk);
      n++;
      if (n > max_cyc) begin
        chk("drain_timeout", 1, 0);
        desc_q.delete(); resp_q.delete(); exp_q.delete();
        break;
      end
    end
    repeat (3) @(negedge clk);
  endtask

  // Source/sink driver: drive at the negedge, sample the handshake just before the posedge.
  initial begin
    bus.desc_valid = 0; bus.desc_id = '0; bus.desc_beats = '0;
    bus.resp_valid = 0; bus.resp_data = '0; bus.sh_cl_dma_pcis_rready = 0;
    forever begin
      @(negedge clk);
      bus.desc_valid = desc_q.size() > 0 && (!rnd_gaps || $urandom_range(3) != 0);
      if (desc_q.size() > 0) begin bus.desc_id = desc_q[0].id; bus.desc_beats = desc_q[0].beats; end
      bus.resp_valid = resp_q.size() > 0 && (!rnd_gaps || $urandom_range(3) != 0);
      if (resp_q.size() > 0) bus.resp_data = resp_q[0];
      case (rr_mode)
        0:       bus.sh_cl_dma_pcis_rready = 1'b1;
        1:       bus.sh_cl_dma_pcis_rready = 1'($urandom_range(1));
        default: bus.sh_cl_dma_pcis_rready = 1'b0;
      endcase
      #4;
      if (bus.desc_valid && bus.desc_ready && desc_q.size() > 0) void'(desc_q.pop_front());
      if (bus.resp_valid && bus.resp_accept && resp_q.size() > 0) void'(resp_q.pop_front());
    end
  end

  // Monitor / scoreboard
  initial begin
    e_t e;
    bit hold = 0;
    logic [ID_WIDTH-1:0] h_id; logic [DATA_WIDTH-1:0] h_data; logic h_last;
    forever begin
      @(negedge clk); #4;
      cyc++;
      if (!rst_n) begin hold = 0; continue; end
      if (hold) begin
        chk("stall_rvalid", bus.cl_sh_dma_pcis_rvalid, 1);
        chk("stall_rid",    bus.cl_sh_dma_pcis_rid, h_id);
        chk("stall_rdata",  bus.cl_sh_dma_pcis_rdata, h_data);
        chk("stall_rlast",  bus.cl_sh_dma_pcis_rlast, h_last);
      end
      if (bus.desc_ready && bus.resp_valid) chk("idle_no_accept", bus.resp_accept, 0);
      if (bus.cl_sh_dma_pcis_rvalid && bus.sh_cl_dma_pcis_rready) begin
        hs_cyc.push_back(cyc);
        if (exp_q.size() == 0) chk("unexpected_beat", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("rid",   bus.cl_sh_dma_pcis_rid, e.id);
          chk("rdata", bus.cl_sh_dma_pcis_rdata, e.data);
          chk("rlast", bus.cl_sh_dma_pcis_rlast, e.last);
          chk("rresp", bus.cl_sh_dma_pcis_rresp, 2'b00);
        end
      end
      hold   = bus.cl_sh_dma_pcis_rvalid && !bus.sh_cl_dma_pcis_rready;
      h_id   = bus.cl_sh_dma_pcis_rid;
      h_data = bus.cl_sh_dma_pcis_rdata;
      h_last = bus.cl_sh_dma_pcis_rlast;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    #4;
    chk("rst_rvalid", bus.cl_sh_dma_pcis_rvalid, 0);
    chk("rst_rlast",  bus.cl_sh_dma_pcis_rlast, 0);
    chk("rst_rid",    bus.cl_sh_dma_pcis_rid, 0);
    chk("rst_rdata",  bus.cl_sh_dma_pcis_rdata, 0);
    chk("rst_desc_ready",  bus.desc_ready, 0);
    chk("rst_resp_accept", bus.resp_accept, 0);
    chk("rst_zero_len_err", bus.zero_len_err, 0);
    @(negedge clk); rst_n = 1;
    @(negedge clk); #4;
    chk("idle_desc_ready", bus.desc_ready, 1);

    // 1: single beat
    send(6'h05, 1, 1'b1);
    drain(50);
    #4 chk("t1_back_to_idle", bus.desc_ready, 1);

    // 2: 4 beats at full throughput
    hs_cyc.delete();
    send(6'h07, 4, 1'b0);
    drain(50);
    chk("t2_beats", hs_cyc.size(), 4);
    if (hs_cyc.size() == 4) chk("t2_span", hs_cyc[3] - hs_cyc[0], 3);

    // 3: 256 beats, rready random
    hs_cyc.delete();
    rr_mode = 1;
    send(6'h2A, 256, 1'b0);
    drain(3000);
    chk("t3_beats", hs_cyc.size(), 256);

    // 4: two queued bursts
    rr_mode = 0;
    send(6'h01, 2, 1'b0);
    send(6'h02, 3, 1'b0);
    drain(100);

    // 5: zero-length descriptor, then a normal one
    hs_cyc.delete();
    send(6'h03, 0, 1'b0);
    send(6'h04, 1, 1'b0);
    drain(50);
    chk("t5_beats", hs_cyc.size(), 1);
    chk("t5_zero_len_err", bus.zero_len_err, 1);

    // Random bursts with random gaps and backpressure
    rr_mode = 1; rnd_gaps = 1;
    for (int b = 0; b < 10; b++) send(ID_WIDTH'($urandom), $urandom_range(1, 8), 1'b0);
    drain(2000);
    chk("rand_zero_len_sticky", bus.zero_len_err, 1);

    // 6: reset mid-burst
    rr_mode = 0; rnd_gaps = 0;
    hs_cyc.delete();
    send(6'h11, 4, 1'b0);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk); #6;
      if (hs_cyc.size() >= 1) begin rr_mode = 2; break; end
    end
    @(negedge clk); @(negedge clk); #2;
    chk("t6_pre_rvalid", bus.cl_sh_dma_pcis_rvalid, 1);
    rst_n = 0;
    #1;
    chk("t6_async_rvalid", bus.cl_sh_dma_pcis_rvalid, 0);
    chk("t6_async_desc_ready", bus.desc_ready, 0);
    chk("t6_async_zero_len_err", bus.zero_len_err, 0);
    desc_q.delete(); resp_q.delete(); exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1;
    rr_mode = 0;
    repeat (2) @(negedge clk);
    #4 chk("t6_idle_no_stale", bus.cl_sh_dma_pcis_rvalid, 0);
    hs_cyc.delete();
    send(6'h12, 2, 1'b0);
    drain(50);
    chk("t6_post_beats", hs_cyc.size(), 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
